// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings and arbiter types.
// Used by the arbiter and the bus masters.
package ahb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HBURST_SINGLE = 3'd0;
  localparam logic [2:0] HBURST_INCR   = 3'd1;
  localparam logic [2:0] HBURST_WRAP4  = 3'd2;
  localparam logic [2:0] HBURST_INCR4  = 3'd3;
  localparam logic [2:0] HBURST_WRAP8  = 3'd4;
  localparam logic [2:0] HBURST_INCR8  = 3'd5;
  localparam logic [2:0] HBURST_WRAP16 = 3'd6;
  localparam logic [2:0] HBURST_INCR16 = 3'd7;

  typedef enum logic [1:0] {
    ST_ARB    = 2'd0,
    ST_BURST  = 2'd1,
    ST_LOCKED = 2'd2
  } arb_state_e;

  // Beats in a burst; 0 means open-ended (INCR).
  function automatic logic [4:0] burst_beats(
    input logic [2:0] hburst
  );
    logic [4:0] n;
    unique case (hburst)
      HBURST_SINGLE: n = 5'd1;
      HBURST_INCR:   n = 5'd0;
      HBURST_WRAP4,
      HBURST_INCR4:  n = 5'd4;
      HBURST_WRAP8,
      HBURST_INCR8:  n = 5'd8;
      default:       n = 5'd16;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/ahb_rr_picker.sv
// Rotating-priority request encoder.
// Owner + 1 is highest priority, owner itself lowest.
module ahb_rr_picker #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx,
  output logic          found
);

  logic [IW-1:0] cand;

  // Scan last+1 .. last+N modulo N for the first request.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    gnt   = '0;
    cand  = '0;
    for (int i = 1; i <= N; i++) begin
      cand = IW'((int'(last) + i) % N);
      if (!found && req[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
    if (found) gnt[idx] = 1'b1;
  end

endmodule

// File: rtl/ahb_arbiter.sv
// Round-robin AHB-Lite arbiter with burst
// and locked-sequence atomicity.
module ahb_arbiter
  import ahb_pkg::*;
#(
  parameter int NUM_MASTERS    = 4,
  parameter int DEFAULT_MASTER = 0
) (
  input  logic                           hclk,
  input  logic                           hresetn,
  input  logic [NUM_MASTERS-1:0]         hbusreq,
  input  logic [NUM_MASTERS-1:0]         hlock,
  input  logic [1:0]                     htrans,
  input  logic [2:0]                     hburst,
  input  logic                           hready,
  output logic [NUM_MASTERS-1:0]         hgrant,
  output logic [$clog2(NUM_MASTERS)-1:0] hmaster,
  output logic                           hmastlock
);

  localparam int MW = $clog2(NUM_MASTERS);
  localparam logic [NUM_MASTERS-1:0] DEF_GNT =
    NUM_MASTERS'(1) << DEFAULT_MASTER;
  localparam logic [MW-1:0] DEF_IDX = MW'(DEFAULT_MASTER);

  arb_state_e    state, state_n;
  logic [3:0]    beats_left, beats_n;
  logic [MW-1:0] owner;

  logic [NUM_MASTERS-1:0] pick_gnt;
  logic [MW-1:0]          pick_idx;
  logic                   pick_found;

  logic [4:0] bb;
  logic [4:0] bb_m1;
  logic       fixed;
  logic       is_idle, is_nseq, is_seq;
  logic       own_req, lock_req;
  logic       hand, arb_ok;

  ahb_rr_picker #(
    .N  (NUM_MASTERS),
    .IW (MW)
  ) u_pick (
    .req   (hbusreq),
    .last  (owner),
    .gnt   (pick_gnt),
    .idx   (pick_idx),
    .found (pick_found)
  );

  assign bb       = burst_beats(hburst);
  assign bb_m1    = bb - 5'd1;
  assign fixed    = |bb[4:2];
  assign is_idle  = (htrans == HTRANS_IDLE);
  assign is_nseq  = (htrans == HTRANS_NONSEQ);
  assign is_seq   = (htrans == HTRANS_SEQ);
  assign own_req  = hbusreq[owner];
  assign lock_req = hlock[owner] & htrans[1];

  // Decide whether the current address phase may end ownership.
  always_comb begin
    hand = 1'b0;
    unique case (1'b1)
      is_idle: hand = 1'b1;
      is_nseq: hand = (hburst == HBURST_SINGLE) ||
                      ((hburst == HBURST_INCR) && !own_req);
      is_seq:  hand = (hburst == HBURST_INCR) ? !own_req
                      : (beats_left == 4'd1);
      default: hand = 1'b0;
    endcase
    arb_ok = hready && (state != ST_LOCKED) &&
             !lock_req && hand;
  end

  // Next FSM state and beat count on accepted transfers.
  always_comb begin
    state_n = state;
    beats_n = beats_left;
    if (hready) begin
      if (is_nseq && fixed)
        beats_n = bb_m1[3:0];
      else if (is_seq && beats_left != 4'd0)
        beats_n = beats_left - 4'd1;
      unique case (state)
        ST_ARB: begin
          if (lock_req)
            state_n = ST_LOCKED;
          else if (is_nseq && fixed)
            state_n = ST_BURST;
        end
        ST_BURST: begin
          if (lock_req)
            state_n = ST_LOCKED;
          else if (is_idle)
            state_n = ST_ARB;
          else if (is_seq && beats_left == 4'd1)
            state_n = ST_ARB;
        end
        ST_LOCKED: begin
          if (!hlock[owner] && is_idle)
            state_n = ST_ARB;
        end
        default: state_n = ST_ARB;
      endcase
    end
  end

  // State, grant and data-phase owner registers.
  always_ff @(posedge hclk) begin
    if (!hresetn) begin
      state      <= ST_ARB;
      beats_left <= 4'd0;
      hgrant     <= DEF_GNT;
      owner      <= DEF_IDX;
      hmaster    <= DEF_IDX;
      hmastlock  <= 1'b0;
    end else begin
      state      <= state_n;
      beats_left <= beats_n;
      if (arb_ok) begin
        hgrant <= pick_found ? pick_gnt : DEF_GNT;
        owner  <= pick_found ? pick_idx : DEF_IDX;
      end
      if (hready) begin
        hmaster   <= owner;
        hmastlock <= hlock[owner];
      end
    end
  end

endmodule

// File: tb/tb_ahb_arbiter.sv
// Scoreboard bench for ahb_arbiter.
// Directed vectors, monitor compares after each edge.
module tb_ahb_arbiter;

  logic       hclk = 1'b0;
  logic       hresetn;
  logic [3:0] hbusreq;
  logic [3:0] hlock;
  logic [1:0] htrans;
  logic [2:0] hburst;
  logic       hready;
  logic [3:0] hgrant;
  logic [1:0] hmaster;
  logic       hmastlock;

  int checks = 0;
  int errors = 0;

  logic [6:0] exp_q[$];
  string      name_q[$];

  always #5 hclk = ~hclk;

  ahb_arbiter #(
    .NUM_MASTERS    (4),
    .DEFAULT_MASTER (0)
  ) dut (
    .hclk      (hclk),
    .hresetn   (hresetn),
    .hbusreq   (hbusreq),
    .hlock     (hlock),
    .htrans    (htrans),
    .hburst    (hburst),
    .hready    (hready),
    .hgrant    (hgrant),
    .hmaster   (hmaster),
    .hmastlock (hmastlock)
  );

  // Monitor: after each edge pop one expectation and compare.
  always begin
    @(posedge hclk);
    #1;
    if (exp_q.size() != 0) begin
      logic [6:0] e;
      logic [6:0] a;
      string      n;
      e = exp_q.pop_front();
      n = name_q.pop_front();
      a = {hgrant, hmaster, hmastlock};
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL %s: got gnt=%b mst=%0d lock=%b, want gnt=%b mst=%0d lock=%b",
                 n, a[6:3], a[2:1], a[0], e[6:3], e[2:1], e[0]);
      end
    end
  end

  // Drive one cycle of inputs and queue the post-edge outputs.
  task automatic step(
    input string      nm,
    input logic       rst_n,
    input logic [3:0] req,
    input logic [3:0] lck,
    input logic [1:0] tr,
    input logic [2:0] bu,
    input logic       rdy,
    input logic [3:0] eg,
    input logic [1:0] em,
    input logic       el
  );
    @(negedge hclk);
    hresetn = rst_n;
    hbusreq = req;
    hlock   = lck;
    htrans  = tr;
    hburst  = bu;
    hready  = rdy;
    exp_q.push_back({eg, em, el});
    name_q.push_back(nm);
  endtask

  localparam logic [1:0] I = 2'b00;
  localparam logic [1:0] B = 2'b01;
  localparam logic [1:0] N = 2'b10;
  localparam logic [1:0] S = 2'b11;

  initial begin
    hresetn = 1'b0;
    hbusreq = '0;
    hlock   = '0;
    htrans  = I;
    hburst  = 3'd0;
    hready  = 1'b1;

    // Reset and park
    step("rst0",  0, 4'b0000, 4'b0000, I, 3'd0, 1, 4'b0001, 0, 0);
    step("rst1",  0, 4'b0000, 4'b0000, I, 3'd0, 1, 4'b0001, 0, 0);
    step("park0", 1, 4'b0000, 4'b0000, I, 3'd0, 1, 4'b0001, 0, 0);
    step("park1", 1, 4'b0000, 4'b0000, I, 3'd0, 1, 4'b0001, 0, 0);

    // Round robin, SINGLE NONSEQ each cycle
    step("rr1", 1, 4'b1111, 4'b0000, N, 3'd0, 1, 4'b0010, 0, 0);
    step("rr2", 1, 4'b1111, 4'b0000, N, 3'd0, 1, 4'b0100, 1, 0);
    step("rr3", 1, 4'b1111, 4'b0000, N, 3'd0, 1, 4'b1000, 2, 0);
    step("rr0", 1, 4'b1111, 4'b0000, N, 3'd0, 1, 4'b0001, 3, 0);
    step("rr1b",1, 4'b1111, 4'b0000, N, 3'd0, 1, 4'b0010, 0, 0);

    // INCR4 by master 1, master 2 waiting
    step("b4_n",  1, 4'b0110, 4'b0000, N, 3'd3, 1, 4'b0010, 1, 0);
    step("b4_s1", 1, 4'b0110, 4'b0000, S, 3'd3, 1, 4'b0010, 1, 0);
    step("b4_s2", 1, 4'b0110, 4'b0000, S, 3'd3, 1, 4'b0010, 1, 0);
    step("b4_s3", 1, 4'b0110, 4'b0000, S, 3'd3, 1, 4'b0100, 1, 0);
    step("b4_nx", 1, 4'b0100, 4'b0000, I, 3'd0, 1, 4'b0100, 2, 0);

    // INCR8 by master 2 with wait states and a BUSY
    step("b8_n",  1, 4'b0110, 4'b0000, N, 3'd5, 1, 4'b0100, 2, 0);
    step("b8_s",  1, 4'b0110, 4'b0000, S, 3'd5, 1, 4'b0100, 2, 0);
    for (int k = 0; k < 3; k++)
      step("b8_wait", 1, 4'b0110, 4'b0000, S, 3'd5, 0,
           4'b0100, 2, 0);
    step("b8_busy", 1, 4'b0110, 4'b0000, B, 3'd5, 1, 4'b0100, 2, 0);
    for (int k = 0; k < 5; k++)
      step("b8_mid", 1, 4'b0110, 4'b0000, S, 3'd5, 1,
           4'b0100, 2, 0);
    step("b8_last", 1, 4'b0110, 4'b0000, S, 3'd5, 1, 4'b0010, 2, 0);
    step("b8_park", 1, 4'b0000, 4'b0000, I, 3'd0, 1, 4'b0001, 1, 0);

    // Locked pair from master 3, everyone requesting
    step("lk_g",  1, 4'b1000, 4'b0000, I, 3'd0, 1, 4'b1000, 0, 0);
    step("lk_a1", 1, 4'b1111, 4'b1000, N, 3'd0, 1, 4'b1000, 3, 1);
    step("lk_a2", 1, 4'b1111, 4'b1000, N, 3'd0, 1, 4'b1000, 3, 1);
    step("lk_id", 1, 4'b1111, 4'b0000, I, 3'd0, 1, 4'b1000, 3, 0);
    step("lk_rl", 1, 4'b1111, 4'b0000, I, 3'd0, 1, 4'b0001, 3, 0);

    // WRAP16 by master 2, reset on the second beat
    step("w_g",   1, 4'b0100, 4'b0000, I, 3'd0, 1, 4'b0100, 0, 0);
    step("w_n",   1, 4'b0110, 4'b0000, N, 3'd6, 1, 4'b0100, 2, 0);
    step("w_rst", 0, 4'b0110, 4'b0000, S, 3'd6, 1, 4'b0001, 0, 0);
    step("w_arb", 1, 4'b0010, 4'b0000, I, 3'd0, 1, 4'b0010, 0, 0);

    // Open INCR by master 1 hands over once it drops its request
    step("i_n",   1, 4'b0110, 4'b0000, N, 3'd1, 1, 4'b0010, 1, 0);
    step("i_s",   1, 4'b0110, 4'b0000, S, 3'd1, 1, 4'b0010, 1, 0);
    step("i_end", 1, 4'b0100, 4'b0000, S, 3'd1, 1, 4'b0100, 1, 0);

    // Drain the scoreboard with a bound
    for (int k = 0; k < 20 && exp_q.size() != 0; k++)
      @(posedge hclk);
    #2;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending, want 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/ahb_arbiter.md
# ahb_arbiter

Round-robin AHB bus arbiter that shares one AHB-Lite address/data path between up to `NUM_MASTERS` ahb_master instances. It samples per-master bus requests and lock requests and drives a one-hot grant. It keeps fixed-length bursts and locked sequences atomic. It publishes the data-phase owner index for the system's master-select muxes and the slave-side `hmastlock`.

## Interface
Parameters:
- `NUM_MASTERS`, 4 — number of requesting masters (2..16).
- `DEFAULT_MASTER`, 0 — index parked on when no request is pending.

Ports:
- `hclk` in 1 — the only clock.
- `hresetn` in 1 — reset, synchronous, active-low.
- `hbusreq` in NUM_MASTERS — per-master bus request.
- `hlock` in NUM_MASTERS — per-master locked-transfer request.
- `htrans` in 2 — transfer type of the currently granted master (muxed).
- `hburst` in 3 — burst type of the currently granted master (muxed).
- `hready` in 1 — bus ready from the slave mux.
- `hgrant` out NUM_MASTERS — one-hot address-phase grant.
- `hmaster` out $clog2(NUM_MASTERS) — index of the address-phase owner, registered for the data phase.
- `hmastlock` out 1 — current transfer is part of a locked sequence.

## Operation
- Encodings:
  - htrans: IDLE 00, BUSY 01, NONSEQ 10, SEQ 11.
  - hburst: SINGLE 0, INCR 1, WRAP4 2, INCR4 3, WRAP8 4, INCR8 5, WRAP16 6, INCR16 7.
- FSM states:
  - ARB: free to re-arbitrate.
  - BURST: fixed-length burst in progress.
  - LOCKED: owner holds `hlock`.
- Beat counter `beats_left` (4 bit):
  - Loaded with burst length − 1 (3/7/15) on an accepted NONSEQ with a fixed hburst. Accepted means `hready`=1. ARB→BURST.
  - Decremented on each accepted SEQ.
  - Reaching 0 returns the FSM to ARB.
  - BUSY holds the counter.
- Handover permitted (`arb_ok`) only when `hready`=1, the FSM is not LOCKED, and one of the following holds:
  - htrans=IDLE;
  - NONSEQ with hburst SINGLE;
  - SEQ with `beats_left`=1, i.e. the last address is being accepted;
  - INCR (NONSEQ or SEQ) with `hbusreq[owner]`=0.
- BUSY never permits handover.
- Round-robin pick:
  - Search indices owner+1, owner+2, … mod NUM_MASTERS for the first asserted `hbusreq`. The owner itself is searched last.
  - No request → grant DEFAULT_MASTER (park).
- Lock:
  - On an accepted address with `hlock[owner]`=1, enter LOCKED.
  - Exit LOCKED to ARB when `hlock[owner]`=0 and an IDLE is accepted.
  - Lock overrides burst end.

## Timing
- Reset values while `hresetn`=0 at a hclk edge:
  - `hgrant` = one-hot DEFAULT_MASTER;
  - `hmaster` = DEFAULT_MASTER;
  - `hmastlock` = 0;
  - `beats_left` = 0;
  - FSM = ARB.
- Reset mid-burst or mid-lock aborts immediately to these values.
- `hgrant` is registered. On the edge where `arb_ok`=1 it updates to the pick, so the new master drives its address in the next cycle. With `arb_ok`=0 it holds.
- `hmaster` and `hmastlock` are registered and update only on edges with `hready`=1. They load the index of the current `hgrant` and `hlock[that index]`. Result: `hmaster` lags `hgrant` by one accepted transfer, matching the AHB data-phase pipeline.
- With `hready`=0, every output and the counter hold.
- Simultaneous requests: at most one grant bit is ever set. Rotation guarantees each requester is granted within NUM_MASTERS handovers.
- Requests deasserted before the handover edge are ignored. The grant is not retracted mid-burst.

## Structure
- Package `ahb_pkg`:
  - HTRANS_* and HBURST_* constants;
  - arbiter state enum;
  - function `burst_beats(hburst)`, returning 1/4/8/16, with 0 meaning undefined (INCR).
  - ahb_master should adopt the same constants.
- Sub-module `ahb_rr_picker`: combinational rotating-priority encoder. Inputs: request vector and last owner. Outputs: one-hot and index.
- The arbiter FSM, beat counter and output registers live in `ahb_arbiter`.

## Test plan
- Reset and park: hresetn=0 for 2 cycles, no requests → hgrant=4'b0001, hmaster=0, hmastlock=0. Held after release.
- Round-robin: hbusreq=4'b1111, owner 0, SINGLE NONSEQ each cycle, hready=1 → grants 1,2,3,0,1 on successive edges.
- Fixed burst atomicity: master 1 issues INCR4 (NONSEQ+3 SEQ), master 2 requesting → hgrant stays 4'b0010 until the 4th address is accepted, then 4'b0100. hmaster=1 for all four data phases, then 2.
- Wait states: insert hready=0 for 3 cycles and a BUSY mid-INCR8 → no grant change, beats_left held. The burst completes with 8 accepted beats.
- Lock: master 3 with hlock=1 over two SINGLE transfers, all others requesting → grant held on 3 and hmastlock=1 during both data phases. Released only after hlock=0 and IDLE accepted.
- Mid-burst reset: hresetn=0 during the 2nd beat of WRAP16 → next edge outputs the reset values, FSM ARB.
